// File: rtl/tilling_pkg.sv
// tilling_pkg
//   Layout definitions shared by the tile-fill buffer and the tile drain
//   (tilling_unbuffer). Both ends derive their half-word, quadrant depth and
//   quadrant width from these functions, so the four-quadrant tile layout
//   is the same on both sides.
//
//   Tile layout (SIZE_OF_INPUT = W, SIZE_OF_BUFFER = N):
//     H  = W/2     half-word width
//     Q  = N/2     entries per quadrant
//     QW = H*Q     quadrant width
//     quadrant n occupies tile[n*QW +: QW]; entry k occupies [k*H +: H].
//     Quadrants 0/1 hold low halves, quadrants 2/3 hold high halves.
package tilling_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,   // no tile held
      PAIR0 = 2'd1,   // emitting {Q2, Q0}
      PAIR1 = 2'd2    // emitting {Q3, Q1}
   } state_t;

   localparam int unsigned NUM_QUADRANTS = 4;

   function automatic int unsigned half_width(input int unsigned size_of_input);
      return size_of_input / 2;
   endfunction

   function automatic int unsigned quad_depth(input int unsigned size_of_buffer);
      return size_of_buffer / 2;
   endfunction

   function automatic int unsigned quad_width(input int unsigned size_of_input,
                                              input int unsigned size_of_buffer);
      return half_width(size_of_input) * quad_depth(size_of_buffer);
   endfunction

   // Width of a counter spanning 0..Q-1; never narrower than one bit.
   function automatic int unsigned beat_width(input int unsigned size_of_buffer);
      if (quad_depth(size_of_buffer) > 1)
         return $clog2(quad_depth(size_of_buffer));
      else
         return 1;
   endfunction

endpackage

// File: rtl/tilling_unbuffer_piso.sv
// piso
//   Parallel-in / serial-out register for one tile quadrant; mirror of the
//   fill-side SIPO. A load captures DEPTH entries of WIDTH bits; each shift
//   moves the next entry into the head position. Entry 0 is at the head
//   right after a load.
//
//   Ports:
//     clk_i   clock, rising edge
//     rst_i   asynchronous active-low reset, clears the register
//     load_i  capture data_i (has priority over shift_i)
//     shift_i advance to the next entry
//     data_i  quadrant contents, entry k at [k*WIDTH +: WIDTH]
//     head_o  entry currently at the head
module piso #(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     load_i,
   input  logic                     shift_i,
   input  logic [WIDTH*DEPTH-1:0]   data_i,
   output logic [WIDTH-1:0]         head_o
);

   logic [WIDTH*DEPTH-1:0] shreg;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         shreg <= '0;
      end else if (load_i) begin
         shreg <= data_i;
      end else if (shift_i) begin
         // Zero-fill from the top; a drained quadrant reads back as zero.
         shreg <= shreg >> WIDTH;
      end
   end

   assign head_o = shreg[WIDTH-1:0];

endmodule

// File: rtl/tilling_unbuffer.sv
// tilling_unbuffer
//   Drain side of the tile-fill buffer. Captures one complete four-quadrant
//   tile and re-serialises it into full-width words, one per handshake.
//   Pair 0 emits {Q2[k], Q0[k]}, pair 1 emits {Q3[k], Q1[k]} for k = 0..Q-1.
//   A new tile can be captured on the final beat of the current one, so
//   consecutive tiles stream without bubbles.
//
//   Ports:
//     clk_i         clock, rising edge
//     rst_i         asynchronous active-low reset
//     tile_valid_i  tile_data_i holds a tile
//     tile_data_i   SIZE_OF_INPUT*SIZE_OF_BUFFER bit tile
//     tile_ready_o  a tile is captured this cycle if tile_valid_i is high
//     out_valid_o   out_data_o holds a word
//     out_data_o    serialised word
//     out_ready_i   consumer accepts the word
//     out_last_o    current word is the final word of the tile
//     is_empty_o    no tile held
//     is_full_o     tile held and not on its final beat
module tilling_unbuffer
   import tilling_pkg::*;
#(
   parameter int unsigned SIZE_OF_INPUT  = 128,
   parameter int unsigned SIZE_OF_BUFFER = 8
) (
   input  logic                                clk_i,
   input  logic                                rst_i,
   input  logic                                tile_valid_i,
   input  logic [SIZE_OF_INPUT*SIZE_OF_BUFFER-1:0] tile_data_i,
   output logic                                tile_ready_o,
   output logic                                out_valid_o,
   output logic [SIZE_OF_INPUT-1:0]            out_data_o,
   input  logic                                out_ready_i,
   output logic                                out_last_o,
   output logic                                is_empty_o,
   output logic                                is_full_o
);

   localparam int unsigned H  = half_width(SIZE_OF_INPUT);
   localparam int unsigned Q  = quad_depth(SIZE_OF_BUFFER);
   localparam int unsigned QW = quad_width(SIZE_OF_INPUT, SIZE_OF_BUFFER);
   localparam int unsigned KW = beat_width(SIZE_OF_BUFFER);

   localparam logic [KW-1:0] K_LAST = KW'(Q - 1);
   localparam logic [KW-1:0] K_ONE  = KW'(1);

   generate
      if ((SIZE_OF_INPUT % 2) != 0 || SIZE_OF_INPUT == 0) begin : g_bad_input
         $error("tilling_unbuffer: SIZE_OF_INPUT must be even and non-zero");
      end
      if ((SIZE_OF_BUFFER % 2) != 0 || SIZE_OF_BUFFER < 2) begin : g_bad_buffer
         $error("tilling_unbuffer: SIZE_OF_BUFFER must be even and >= 2");
      end
   endgenerate

   state_t        state;
   logic [KW-1:0] k;
   logic          valid_q;
   logic          last_q;
   logic          ready_en;   // low in reset and until the first edge after it

   logic          capture;
   logic          advance;
   logic [H-1:0]  quad_head [NUM_QUADRANTS];
   logic [NUM_QUADRANTS-1:0] quad_shift;

   // Ready on the final beat depends combinationally on out_ready_i so the
   // next tile is captured on the same edge the last word leaves.
   assign tile_ready_o = ready_en && ((state == IDLE) || (last_q && out_ready_i));
   assign capture      = tile_valid_i && tile_ready_o;
   assign advance      = valid_q && out_ready_i;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state    <= IDLE;
         k        <= '0;
         valid_q  <= 1'b0;
         last_q   <= 1'b0;
         ready_en <= 1'b0;
      end else begin
         ready_en <= 1'b1;
         if (capture) begin
            state   <= PAIR0;
            k       <= '0;
            valid_q <= 1'b1;
            last_q  <= 1'b0;
         end else if (advance) begin
            if (k != K_LAST) begin
               k      <= k + K_ONE;
               last_q <= (state == PAIR1) && ((k + K_ONE) == K_LAST);
            end else if (state == PAIR0) begin
               state  <= PAIR1;
               k      <= '0;
               last_q <= (K_LAST == '0);
            end else begin
               state   <= IDLE;
               k       <= '0;
               valid_q <= 1'b0;
               last_q  <= 1'b0;
            end
         end
      end
   end

   // Even quadrants (0, 2) drain during PAIR0, odd quadrants (1, 3) during
   // PAIR1; all four share the load strobe.
   always_comb begin
      quad_shift = '0;
      for (int unsigned q = 0; q < NUM_QUADRANTS; q++) begin
         if ((q % 2) == 0)
            quad_shift[q] = advance && (state == PAIR0);
         else
            quad_shift[q] = advance && (state == PAIR1);
      end
   end

   generate
      for (genvar q = 0; q < NUM_QUADRANTS; q++) begin : g_quad
         piso #(
            .WIDTH (H),
            .DEPTH (Q)
         ) u_piso (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .load_i  (capture),
            .shift_i (quad_shift[q]),
            .data_i  (tile_data_i[q*QW +: QW]),
            .head_o  (quad_head[q])
         );
      end
   endgenerate

   always_comb begin
      if (state == PAIR1)
         out_data_o = {quad_head[3], quad_head[1]};
      else
         out_data_o = {quad_head[2], quad_head[0]};
   end

   assign out_valid_o = valid_q;
   assign out_last_o  = last_q;
   assign is_empty_o  = (state == IDLE);
   assign is_full_o   = valid_q && !last_q;

endmodule

// File: doc/tilling_unbuffer.md
# tilling_unbuffer

Drain-side counterpart of the tile-fill buffer. It accepts one complete tile in the four-quadrant layout produced by the fill buffer: quadrants 0/1 carry the low halves of input words and quadrants 2/3 carry the high halves. It then re-serialises the tile into full-width words, one word per handshake. It sits between the tile compute/storage stage and any word-wide consumer (output DMA, next-stage stream), and supports back-to-back tiles without bubbles.

## Interface
- `SIZE_OF_INPUT`, 128, output word width; must be even.
- `SIZE_OF_BUFFER`, 8, words per tile; must be even and ≥2.
- Derived constants:
  - H = SIZE_OF_INPUT/2 (half-word)
  - Q = SIZE_OF_BUFFER/2 (entries per quadrant)
  - QW = H*Q (quadrant width)
- `clk_i`  in  1  clock; all logic is rising-edge.
- `rst_i`  in  1  reset, asynchronous assert, active-low.
- `tile_valid_i`  in  1  tile on `tile_data_i` is valid.
- `tile_data_i`  in  SIZE_OF_INPUT*SIZE_OF_BUFFER  tile; quadrant n occupies [n*QW +: QW], entry k of a quadrant occupies [k*H +: H], and entry 0 is emitted first.
- `tile_ready_o`  out  1  block can capture a tile this cycle.
- `out_valid_o`  out  1  `out_data_o` holds a valid word.
- `out_data_o`  out  SIZE_OF_INPUT  serialised word.
- `out_ready_i`  in  1  consumer accepts the word.
- `out_last_o`  out  1  current word is the final word of the tile.
- `is_empty_o`  out  1  no tile held.
- `is_full_o`  out  1  tile held and not on its final beat.

## Operation
- FSM states:
  - IDLE: no tile held.
  - PAIR0: emitting quadrant pair (lo = Q0, hi = Q2).
  - PAIR1: emitting pair (lo = Q1, hi = Q3).
- Beat counter `k`, range 0..Q-1. Word at state PAIRp, count k = {tile[(2+p)*QW + k*H +: H], tile[p*QW + k*H +: H]}.
- Tile capture occurs when `tile_valid_i && tile_ready_o`. The whole tile is latched into an internal register, the FSM goes to PAIR0, and `k` is set to 0.
- Readiness:
  - `tile_ready_o` = (state==IDLE) | (state==PAIR1 && k==Q-1 && out_ready_i).
  - It is combinational on `out_ready_i`, which enables zero-bubble reload.
- `out_valid_o` = (state != IDLE).
- `out_last_o` = (state==PAIR1 && k==Q-1).
- Word advance occurs on `out_valid_o && out_ready_i`:
  - k<Q-1: k+1.
  - PAIR0 with k==Q-1: PAIR1, k=0.
  - PAIR1 with k==Q-1: capture a new tile if one is offered (PAIR0, k=0), otherwise go to IDLE.
- `out_data_o` and `out_valid_o` are held stable while `out_valid_o && !out_ready_i`.
- `tile_valid_i` is ignored when `tile_ready_o` is low; the upstream source must hold it.
- `is_empty_o` = (state==IDLE). `is_full_o` = !is_empty_o && !out_last_o.

## Timing
- Reset (`rst_i` low, immediate):
  - state IDLE, k=0, tile register 0.
  - `out_valid_o`=0, `out_last_o`=0, `out_data_o`=0, `is_empty_o`=1, `is_full_o`=0.
  - `tile_ready_o`=0 while in reset; 1 from the first cycle after deassertion.
- Latency: a tile captured at edge N presents word 0 with `out_valid_o`=1 in the cycle after N.
- Throughput: one word per cycle under continuous `out_ready_i`. Consecutive tiles produce SIZE_OF_BUFFER words each with no idle cycle between them.
- A tile takes exactly SIZE_OF_BUFFER accepted beats, with `out_last_o` asserted on exactly one of them.
- Reset mid-tile discards the remaining words; no partial tile resumes.

## Structure
- Shared package/header `tilling_pkg` holds:
  - the state encoding (IDLE=2'd0, PAIR0=2'd1, PAIR1=2'd2);
  - the H/Q/QW derivation macros, shared with the fill-side buffer so both ends use an identical layout.
- One natural sub-module is `piso` (mirror of the fill-side SIPO), parameterised by SIZE_OF_INPUT/2 and SIZE_OF_BUFFER/2. Four instances, one per quadrant, share the load strobe. Lo/hi pairs are selected by the FSM.

## Test plan
All scenarios use the defaults: H=64, Q=4, QW=256, tile is 1024 bits.
- Quadrant tagging: quadrant q entry k = 64'h(q*16+k). Offer the tile with `out_ready_i`=1 → 8 words in order:
  - {0x20,0x00}, {0x21,0x01}, {0x22,0x02}, {0x23,0x03}
  - {0x30,0x10}, {0x31,0x11}, {0x32,0x12}, {0x33,0x13}
  - `out_last_o` high only on the 8th word.
- Backpressure: `out_ready_i` low for 3 cycles on beat 2 → `out_data_o`={0x22,0x02} held stable, beat 3 follows on the cycle after release.
- Back-to-back: second tile held valid during the first → `tile_ready_o` pulses only on beat 7. 16 consecutive valid words result, no gap, `out_last_o` on words 8 and 16.
- Early offer: `tile_valid_i` asserted during beat 3 → no capture, first tile output unchanged.
- Reset mid-tile: `rst_i` low at beat 5 → `out_valid_o`=0 and `is_empty_o`=1 asynchronously. The next tile after release starts at word 0.
- Idle status: after reset with no tile → `is_empty_o`=1, `is_full_o`=0, `tile_ready_o`=1. After capture → `is_full_o`=1 until beat 7.
